// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin arbiter granting NUM_REQ requesters access to
// one shared buffer port. Three-state FSM: IDLE -> GRANT -> RELEASE -> IDLE.
// Optional watchdog that aborts a stalled GRANT: define BUFFER_ARB_WATCHDOG_EN.
module buffer_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDRESS_SIZE   = 9,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            buf_re,
    output logic                            buf_we,
    output logic [ADDRESS_SIZE-1:0]         buf_address,
    input  logic                            buf_done,
    output logic [NUM_REQ-1:0]              req_done,
    output logic                            busy,
    output logic                            timeout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [PTR_W-1:0]          ptr, ptr_nxt;
    logic [PTR_W-1:0]          win_idx;
    logic [PTR_W-1:0]          cand_idx;
    logic                      win_found;
    logic [NUM_REQ-1:0]        gnt_nxt;
    logic [NUM_REQ-1:0]        req_done_nxt;
    logic                      buf_re_nxt;
    logic                      buf_we_nxt;
    logic [ADDRESS_SIZE-1:0]   addr_nxt;
    logic                      busy_nxt;
    logic                      timeout_nxt;
    logic                      wd_hit;
    logic [ADDRESS_SIZE-1:0]   addr_arr [NUM_REQ];

    // Unpack the flat address bus into one entry per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
    end

`ifdef BUFFER_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [WD_W-1:0] wd_cnt;

    // Limit is hit in the last allowed GRANT cycle, so GRANT lasts TIMEOUT_CYCLES cycles.
    assign wd_hit = (state == GRANT) && ((32'(wd_cnt) + 32'd1) >= TIMEOUT_CYCLES);

    // GRANT-cycle counter; held at zero outside GRANT so every grant starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == GRANT) begin
            wd_cnt <= WD_W'(wd_cnt + 1'b1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_hit = 1'b0;

    // Limit is only meaningful with the watchdog built; keep the parameter referenced.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout_limit
    end
`endif

    // Round-robin search: first requesting index at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gnt_nxt      = gnt;
        buf_re_nxt   = buf_re;
        buf_we_nxt   = buf_we;
        addr_nxt     = buf_address;
        req_done_nxt = '0;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = NUM_REQ'(1) << win_idx;
                    addr_nxt   = addr_arr[win_idx];
                    buf_we_nxt = req_we[win_idx];
                    buf_re_nxt = ~req_we[win_idx];
                    ptr_nxt    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(win_idx + 1'b1);
                end
            end
            GRANT: begin
                // buf_done wins over a simultaneous watchdog limit.
                if (buf_done) begin
                    state_nxt    = RELEASE;
                    gnt_nxt      = '0;
                    buf_re_nxt   = 1'b0;
                    buf_we_nxt   = 1'b0;
                    req_done_nxt = gnt;
                end else if (wd_hit) begin
                    state_nxt   = RELEASE;
                    gnt_nxt     = '0;
                    buf_re_nxt  = 1'b0;
                    buf_we_nxt  = 1'b0;
                    timeout_nxt = 1'b1;
                end
            end
            RELEASE: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                buf_re_nxt = 1'b0;
                buf_we_nxt = 1'b0;
            end
            default: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                buf_re_nxt = 1'b0;
                buf_we_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            buf_re      <= 1'b0;
            buf_we      <= 1'b0;
            buf_address <= '0;
            req_done    <= '0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gnt         <= gnt_nxt;
            buf_re      <= buf_re_nxt;
            buf_we      <= buf_we_nxt;
            buf_address <= addr_nxt;
            req_done    <= req_done_nxt;
            busy        <= busy_nxt;
            timeout     <= timeout_nxt;
        end
    end

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the unified buffer port.
REQ-002 Parameter ADDRESS_SIZE, default 9: buffer address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles; used only when the watchdog is compiled in.
REQ-004 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port req  input  NUM_REQ  per-requester access request, level.
REQ-007 Port req_we  input  NUM_REQ  per-requester operation: 1 = write, 0 = read.
REQ-008 Port req_addr  input  NUM_REQ*ADDRESS_SIZE  packed addresses; requester i occupies bits [i*ADDRESS_SIZE +: ADDRESS_SIZE].
REQ-009 Port gnt  output  NUM_REQ  one-hot grant, or all zero.
REQ-010 Port buf_re  output  1  buffer read enable.
REQ-011 Port buf_we  output  1  buffer write enable.
REQ-012 Port buf_address  output  ADDRESS_SIZE  buffer address.
REQ-013 Port buf_done  input  1  buffer reports that the current access is complete.
REQ-014 Port req_done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-015 Port busy  output  1  high whenever the state is not IDLE.
REQ-016 Port timeout  output  1  one-cycle watchdog-abort pulse.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-018 In IDLE with any req bit set, the arbiter SHALL select the winner by round-robin starting at priority pointer ptr, and move to GRANT on the next edge.
REQ-019 On entry to GRANT, the arbiter SHALL register and hold constant until RELEASE:
- gnt = one-hot of the winner
- buf_address = the winner's req_addr slice
- buf_we = req_we[winner]
- buf_re = ~req_we[winner]
REQ-020 Latency: req seen in IDLE at edge n SHALL produce gnt and enables valid after edge n+1.
REQ-021 In GRANT, buf_done=1 SHALL cause the following edge to:
- enter RELEASE
- clear gnt, buf_re and buf_we
- pulse req_done[winner] for exactly one cycle
REQ-022 RELEASE SHALL last exactly one cycle, with all enables low, and then return to IDLE.
- Minimum spacing between successive grants is therefore 3 cycles.
REQ-023 ptr SHALL update on entry to GRANT to (winner+1) mod NUM_REQ.
REQ-024 A req deasserted while granted SHALL be ignored; the grant is held until buf_done or the watchdog ends it.
REQ-025 req and buf_done SHALL be ignored in RELEASE. buf_done SHALL be ignored in IDLE.
REQ-026 buf_re and buf_we SHALL never both be 1, and at most one gnt bit SHALL be 1 in any cycle.
REQ-027 buf_address SHALL retain its last value when not in GRANT.

Reset
REQ-028 While rst=1, independent of clk, the block SHALL hold:
- state = IDLE, ptr = 0
- gnt, req_done, buf_re, buf_we, busy and timeout = 0
- buf_address = 0
REQ-029 Reset asserted during GRANT SHALL abort the access with no req_done pulse. Arbitration SHALL resume from ptr=0 on the first edge after rst falls.

Configuration
REQ-030 With macro BUFFER_ARB_WATCHDOG_EN defined, the arbiter SHALL implement a GRANT-cycle counter that clears on GRANT entry.
- If the counter reaches TIMEOUT_CYCLES without buf_done, the next edge SHALL enter RELEASE, clear the enables and pulse timeout for 1 cycle.
- req_done SHALL NOT be pulsed on a watchdog abort.
- buf_done and the limit reached in the same cycle SHALL count as normal completion.
REQ-031 Without BUFFER_ARB_WATCHDOG_EN, GRANT SHALL wait indefinitely for buf_done, timeout SHALL be tied to 0, and no counter SHALL be built.

Verification
REQ-032 Single request: req=4'b0010, req_we=0, addr1=9'h0A5, buf_done 4 cycles after grant -> gnt=4'b0010, buf_re=1, buf_address=9'h0A5, then req_done=4'b0010 for one cycle and busy returns to 0.
REQ-033 Fairness: req=4'b1111 held, each grant completed after 1 cycle -> grant order 0,1,2,3,0, with 3-cycle grant spacing.
REQ-034 Write path: requester 3, req_we=1, addr=9'h1FF -> buf_we=1, buf_re=0, buf_address=9'h1FF; req dropped mid-grant -> gnt held until buf_done.
REQ-035 Reset mid-grant: rst pulsed while gnt=4'b0100 -> all outputs 0 immediately with no clock edge, no req_done, and next grant goes to the lowest pending index.
REQ-036 Watchdog (macro on, TIMEOUT_CYCLES=8): buf_done never asserted -> timeout pulse after 8 GRANT cycles with req_done=0; macro off -> gnt held for 1000 cycles.
